// File: rtl/hold_drain_reader_if.sv
// Bit-in / word-out signal bundle for hold_drain_reader.
// HOLD_DRAIN_READER_PARITY_EN adds the out_err flag.
interface hold_drain_reader_if #(
  parameter int WIDTH = 8
);
  logic             hold_valid;
  logic             hold_data;
  logic             drain;
  logic             out_valid;
  logic [WIDTH-1:0] out_data;
  logic             out_ready;
`ifdef HOLD_DRAIN_READER_PARITY_EN
  logic             out_err;

  modport slave (
    input  hold_valid, hold_data, out_ready,
    output drain, out_valid, out_data, out_err
  );
  modport master (
    output hold_valid, hold_data, out_ready,
    input  drain, out_valid, out_data, out_err
  );
`else
  modport slave (
    input  hold_valid, hold_data, out_ready,
    output drain, out_valid, out_data
  );
  modport master (
    output hold_valid, hold_data, out_ready,
    input  drain, out_valid, out_data
  );
`endif
endinterface

// File: rtl/hold_drain_reader.sv
// Drains the single-entry holding register one bit per cycle and packs the bits LSB-first
// into WIDTH-bit words. HOLD_DRAIN_READER_PARITY_EN appends an even-parity bit per frame.
//
// state | meaning
// FILL  | collecting bits of the current frame
// FULL  | completed word presented, waiting for out_ready
module hold_drain_reader #(
  parameter int WIDTH = 8
) (
  input  logic                  clk,
  input  logic                  rst_n,
  hold_drain_reader_if.slave    bus
);
`ifdef HOLD_DRAIN_READER_PARITY_EN
  localparam int FRAME = WIDTH + 1;
`else
  localparam int FRAME = WIDTH;
`endif
  localparam int CW = $clog2(WIDTH + 1);
  localparam logic [CW-1:0] LAST = CW'(FRAME - 1);

  typedef enum logic {FILL = 1'b0, FULL = 1'b1} state_e;

  state_e           state_q, state_d;
  logic [CW-1:0]    cnt_q, cnt_d;
  logic [WIDTH-1:0] shift_q, shift_d;
  logic [WIDTH-1:0] out_data_q, out_data_d;
  logic             drain_s;
`ifdef HOLD_DRAIN_READER_PARITY_EN
  logic             err_q, err_d;
`endif

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q    <= FILL;
      cnt_q      <= '0;
      shift_q    <= '0;
      out_data_q <= '0;
`ifdef HOLD_DRAIN_READER_PARITY_EN
      err_q      <= 1'b0;
`endif
    end else begin
      state_q    <= state_d;
      cnt_q      <= cnt_d;
      shift_q    <= shift_d;
      out_data_q <= out_data_d;
`ifdef HOLD_DRAIN_READER_PARITY_EN
      err_q      <= err_d;
`endif
    end
  end

  always_comb begin
    state_d    = state_q;
    cnt_d      = cnt_q;
    shift_d    = shift_q;
    out_data_d = out_data_q;
`ifdef HOLD_DRAIN_READER_PARITY_EN
    err_d      = err_q;
`endif
    // In FULL a pop is only allowed when the held word leaves on the same edge.
    drain_s = rst_n & bus.hold_valid & ((state_q == FILL) | bus.out_ready);

    if (state_q == FULL && bus.out_ready) begin
      state_d = FILL;
`ifdef HOLD_DRAIN_READER_PARITY_EN
      err_d   = 1'b0;
`endif
    end

    if (drain_s) begin
      for (int i = 0; i < WIDTH; i++) begin
        if (cnt_q == CW'(i)) shift_d[i] = bus.hold_data;
      end
      if (cnt_q == LAST) begin
        state_d    = FULL;
        cnt_d      = '0;
        out_data_d = shift_d;
`ifdef HOLD_DRAIN_READER_PARITY_EN
        err_d      = (^shift_q) ^ bus.hold_data;
`endif
      end else begin
        cnt_d = cnt_q + CW'(1);
      end
    end
  end

  assign bus.drain     = drain_s;
  assign bus.out_valid = (state_q == FULL);
  assign bus.out_data  = out_data_q;
`ifdef HOLD_DRAIN_READER_PARITY_EN
  assign bus.out_err   = err_q;
`endif
endmodule

// File: tb/tb_hold_drain_reader.sv
// Self-checking bench for hold_drain_reader: directed scenarios plus random traffic,
// compared cycle by cycle against a frame-level reference model.
module tb_hold_drain_reader;
  localparam int WIDTH = 8;
`ifdef HOLD_DRAIN_READER_PARITY_EN
  localparam int FR = WIDTH + 1;
`else
  localparam int FR = WIDTH;
`endif

  logic clk = 1'b0;
  logic rst_n;
  int   n_chk = 0;
  int   n_err = 0;

  hold_drain_reader_if #(.WIDTH(WIDTH)) hif ();

  hold_drain_reader #(.WIDTH(WIDTH)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (hif.slave)
  );

  always #5 clk = ~clk;

  // Reference model: bits received so far in the current frame, and the word on offer.
  int               fill_n;
  logic [31:0]      acc;
  logic             pend_v;
  logic [WIDTH-1:0] pend_d;
  logic             pend_e;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_chk++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, obs, exp, $time);
    end
  endtask

  task automatic cycle(input logic r, input logic hv, input logic hd, input logic rdy);
    logic exp_dr;
    rst_n          = r;
    hif.hold_valid = hv;
    hif.hold_data  = hd;
    hif.out_ready  = rdy;
    exp_dr = r && hv && (!pend_v || rdy);
    @(negedge clk);
    check("drain", 32'(hif.drain), 32'(exp_dr));
    check("out_valid", 32'(hif.out_valid), 32'(pend_v));
    if (pend_v) check("out_data", 32'(hif.out_data), 32'(pend_d));
`ifdef HOLD_DRAIN_READER_PARITY_EN
    check("out_err", 32'(hif.out_err), 32'(pend_v ? pend_e : 1'b0));
`endif
    @(posedge clk);
    if (!r) begin
      fill_n = 0;
      acc    = '0;
      pend_v = 1'b0;
      pend_d = '0;
      pend_e = 1'b0;
    end else begin
      if (pend_v && rdy) pend_v = 1'b0;
      if (exp_dr) begin
        acc[fill_n] = hd;
        fill_n++;
        if (fill_n == FR) begin
          pend_v = 1'b1;
          pend_d = acc[WIDTH-1:0];
          pend_e = ^acc[FR-1:0];
          fill_n = 0;
          acc    = '0;
        end
      end
    end
    #1;
  endtask

  // Frame for a data word; in parity builds the appended bit is correct unless bad=1.
  function automatic logic [31:0] frame(input logic [31:0] d, input logic bad);
    logic [31:0] f;
    f = d & 32'(2**WIDTH - 1);
`ifdef HOLD_DRAIN_READER_PARITY_EN
    f[WIDTH] = (^d[WIDTH-1:0]) ^ bad;
`else
    f = f ^ 32'(bad & 1'b0);
`endif
    return f;
  endfunction

  task automatic send_bits(input logic [31:0] v, input int n, input logic rdy, input int maxgap);
    for (int i = 0; i < n; i++) begin
      if (maxgap > 0) begin
        int g = $urandom_range(1, maxgap);
        for (int k = 0; k < g; k++) cycle(1'b1, 1'b0, 1'($urandom_range(0, 1)), rdy);
      end
      cycle(1'b1, 1'b1, v[i], rdy);
    end
  endtask

  initial begin
    fill_n = 0; acc = '0; pend_v = 1'b0; pend_d = '0; pend_e = 1'b0;

    // Reset with the upstream already valid: nothing may be drained.
    cycle(1'b0, 1'b1, 1'b1, 1'b1);
    cycle(1'b0, 1'b1, 1'b0, 1'b0);
    check("rst_valid", 32'(hif.out_valid), 32'd0);
    check("rst_data", 32'(hif.out_data), 32'd0);

    // Continuous stream 1,0,1,1,0,0,1,0 -> 8'h4D.
    send_bits(frame(32'h4D, 1'b0), FR, 1'b1, 0);
    check("t1_valid", 32'(hif.out_valid), 32'd1);
    check("t1_data", 32'(hif.out_data), 32'h4D);
    cycle(1'b1, 1'b0, 1'b0, 1'b1);

    // Backpressure: word held, upstream bit not consumed.
    send_bits(frame(32'h4D, 1'b0), FR, 1'b0, 0);
    for (int i = 0; i < 3; i++) cycle(1'b1, 1'b1, 1'b0, 1'b0);
    check("t2_hold", 32'(hif.out_data), 32'h4D);
    send_bits(frame(32'h96, 1'b0), FR, 1'b1, 0);
    check("t2_next", 32'(hif.out_data), 32'h96);
    cycle(1'b1, 1'b0, 1'b0, 1'b1);

    // Gapped upstream.
    send_bits(frame(32'hA5, 1'b0), FR, 1'b1, 5);
    check("t3_data", 32'(hif.out_data), 32'hA5);
    cycle(1'b1, 1'b0, 1'b0, 1'b1);

    // Reset mid-word discards the partial bits.
    send_bits(32'h1F, 5, 1'b1, 0);
    cycle(1'b0, 1'b0, 1'b0, 1'b0);
    send_bits(frame(32'h3C, 1'b0), FR, 1'b1, 0);
    check("t4_data", 32'(hif.out_data), 32'h3C);

    // Reset while FULL, upstream valid during reset.
    cycle(1'b1, 1'b0, 1'b0, 1'b1);
    send_bits(frame(32'h5A, 1'b0), FR, 1'b0, 0);
    cycle(1'b0, 1'b1, 1'b1, 1'b0);
    cycle(1'b1, 1'b0, 1'b0, 1'b0);
    check("t5_valid", 32'(hif.out_valid), 32'd0);

`ifdef HOLD_DRAIN_READER_PARITY_EN
    send_bits(frame(32'h4D, 1'b0), FR, 1'b1, 0);
    check("par_ok_err", 32'(hif.out_err), 32'd0);
    check("par_ok_data", 32'(hif.out_data), 32'h4D);
    send_bits(frame(32'h4D, 1'b1), FR, 1'b1, 0);
    check("par_bad_err", 32'(hif.out_err), 32'd1);
    check("par_bad_data", 32'(hif.out_data), 32'h4D);
    cycle(1'b1, 1'b0, 1'b0, 1'b1);
`endif

    // Random traffic with rare resets.
    for (int i = 0; i < 4000; i++) begin
      cycle(1'($urandom_range(0, 199) != 0),
            1'($urandom_range(0, 9) < 7),
            1'($urandom_range(0, 1)),
            1'($urandom_range(0, 9) < 6));
    end

    $display("Simulation finished: %0d checks, %0d errors", n_chk, n_err);
    $finish;
  end
endmodule
